soc_system_pio_stream_out: RTL and testbench
============================================

SOC_SYSTEM_PIO_STREAM_OUT -- requirements
Module: soc_system_pio_stream_out

Interface
REQ-001 Parameter DATA_W, default 32: width of data words, writedata, readdata and out_data; legal range 1..32.
REQ-002 Parameter DEPTH, default 8: FIFO depth in words; power of two, 2..256.
REQ-003 Parameter LOW_WM, default 2: low watermark for irq; legal range 0..DEPTH-1.
REQ-004 clk  in  1  single clock; all logic is synchronous to its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 address  in  2  Avalon-MM slave word address.
REQ-007 chipselect  in  1  Avalon-MM select.
REQ-008 write_n  in  1  Avalon-MM write strobe, active low.
REQ-009 writedata  in  32  Avalon-MM write data.
REQ-010 readdata  out  32  Avalon-MM read data, combinational, zero wait states.
REQ-011 out_data  out  DATA_W  stream word at FIFO head.
REQ-012 out_valid  out  1  out_data is valid.
REQ-013 out_ready  in  1  consumer accepts the word.
REQ-014 irq  out  1  level interrupt, active high.

Function
REQ-015 The block SHALL write, i.e. wr = chipselect & ~write_n, and decode the register map: 0 PUSH/HEAD, 1 STATUS, 2 CTRL, 3 LAST.
REQ-016 The block SHALL push writedata[DATA_W-1:0] on wr to address 0 when not full; when full, the word is dropped and OVF is set sticky.
REQ-017 The block SHALL pop on out_valid & out_ready.
REQ-018 When a push and a pop occur in the same cycle, count SHALL stay unchanged, including at full (the push is accepted) and at count=1.
REQ-019 A push into an empty FIFO SHALL raise out_valid on the next cycle; the FIFO has no combinational fall-through.
REQ-020 While out_valid=1 and out_ready=0, out_data SHALL hold stable.
REQ-021 Pointers SHALL wrap modulo DEPTH; count width is CNT_W = log2(DEPTH)+1, range 0..DEPTH.
REQ-022 STATUS read SHALL return: [CNT_W-1:0] count, bit 16 empty, bit 17 full, bit 18 OVF, all other bits 0.
REQ-023 CTRL write SHALL act as follows: bit0 FLUSH (self-clearing) empties the FIFO next cycle and takes priority over a same-cycle pop; bit1 clears OVF; bit2 IRQ_EN is stored.
REQ-024 CTRL read SHALL return only IRQ_EN in bit2; all other bits read 0.
REQ-025 Address 0 read SHALL return the head word zero-extended, or 0 when empty; reads have no side effects.
REQ-026 Address 3 read SHALL return the last accepted push word zero-extended; dropped pushes do not update it.
REQ-027 The block SHALL drive irq = IRQ_EN & (count <= LOW_WM), registered, with one cycle of latency after a count change.
REQ-028 Writes to STATUS SHALL be ignored.

Reset
REQ-029 While reset=1 at a clk edge, the block SHALL clear pointers, count, OVF, IRQ_EN, LAST and the irq register, giving out_valid=0, irq=0 and out_data=0.
REQ-030 Reset mid-stream SHALL discard all queued words; FIFO memory contents need not be cleared.

Structure
REQ-031 Package soc_system_pio_pkg SHALL hold the register offsets, the STATUS and CTRL bit positions, and a clog2 function.
REQ-032 The FIFO storage and pointers SHALL live in sub-module soc_system_pio_sync_fifo (DATA_W, DEPTH), which provides push/pop/flush, count, full and empty.
REQ-033 The top level SHALL contain only the Avalon decode, the CTRL/OVF/LAST registers, the read mux and the irq register.

Verification
REQ-034 Push 0x11, 0x22, 0x33 with out_ready=0 -> out_valid=1 one cycle after the first push; STATUS=0x3; head=0x11; out_data stays 0x11.
REQ-035 DEPTH=8: push 9 words with out_ready=0 -> STATUS=0x20008 before the 9th push and 0x60008 after it (full, OVF); LAST = 8th word; write CTRL=0x2 -> OVF cleared.
REQ-036 Full FIFO: push 0xAA while out_ready=1 -> count stays 8; 0xAA is delivered after the existing 8 words.
REQ-037 Set IRQ_EN, LOW_WM=2, count=4; drain with out_ready=1 -> irq rises one cycle after count reaches 2.
REQ-038 Count=5; write CTRL=0x1 while out_ready=1 -> next cycle out_valid=0, STATUS=0x10000; no pop is counted.
REQ-039 Assert reset with count=3, OVF=1, IRQ_EN=1 -> next cycle STATUS=0x10000, CTRL=0, irq=0, LAST=0.

Source files
------------

// File: rtl/soc_system_pio_pkg.sv
// Shared register map, bit positions and helpers for the PIO stream-out block.
package soc_system_pio_pkg;

    localparam logic [1:0] ADDR_PUSH   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_LAST   = 2'd3;

    localparam int unsigned STATUS_EMPTY_BIT = 16;
    localparam int unsigned STATUS_FULL_BIT  = 17;
    localparam int unsigned STATUS_OVF_BIT   = 18;

    localparam int unsigned CTRL_FLUSH_BIT   = 0;
    localparam int unsigned CTRL_CLR_OVF_BIT = 1;
    localparam int unsigned CTRL_IRQ_EN_BIT  = 2;

    // STATUS word layout as seen on readdata
    typedef struct packed {
        logic [12:0] rsvd;
        logic        ovf;
        logic        full;
        logic        empty;
        logic [15:0] count;
    } status_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/soc_system_pio_sync_fifo.sv
// Synchronous FIFO with registered head (no fall-through); push at full is
// accepted only when a pop frees a slot in the same cycle.
module soc_system_pio_sync_fifo
    import soc_system_pio_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    input  logic                  flush,
    output logic                  push_ok,
    output logic [DATA_W-1:0]     head,
    output logic [clog2(DEPTH):0] count,
    output logic                  full,
    output logic                  empty
);

    localparam int unsigned AW    = clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign push_ok = push & (~full | do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointers and occupancy; flush outranks any same-cycle pop
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !push_ok) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/soc_system_pio_stream_out.sv
// Avalon-MM slave that queues written words and streams them out, with
// sticky overflow, last-word capture and a low-watermark interrupt.
module soc_system_pio_stream_out
    import soc_system_pio_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned LOW_WM = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              irq
);

    localparam int unsigned CNT_W = clog2(DEPTH) + 1;

    logic              wr;
    logic              push_req;
    logic              ctrl_wr;
    logic              flush;
    logic              pop;
    logic              push_ok;
    logic [DATA_W-1:0] head;
    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              ovf;
    logic              irq_en;
    logic [DATA_W-1:0] last_word;
    status_t           status;

    assign wr       = chipselect & ~write_n;
    assign push_req = wr && (address == ADDR_PUSH);
    assign ctrl_wr  = wr && (address == ADDR_CTRL);
    assign flush    = ctrl_wr & writedata[CTRL_FLUSH_BIT];
    assign pop      = out_valid & out_ready;

    assign out_valid = ~empty;
    assign out_data  = head;

    soc_system_pio_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_req),
        .push_data (writedata[DATA_W-1:0]),
        .pop       (pop),
        .flush     (flush),
        .push_ok   (push_ok),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Control/status registers; irq follows count with one cycle of latency
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf       <= 1'b0;
            irq_en    <= 1'b0;
            last_word <= '0;
            irq       <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en <= writedata[CTRL_IRQ_EN_BIT];
            if (ctrl_wr && writedata[CTRL_CLR_OVF_BIT]) ovf <= 1'b0;
            else if (push_req && !push_ok)             ovf <= 1'b1;
            if (push_ok) last_word <= writedata[DATA_W-1:0];
            irq <= irq_en & (count <= CNT_W'(LOW_WM));
        end
    end

    always_comb begin
        status       = '0;
        status.count = 16'(count);
        status.empty = empty;
        status.full  = full;
        status.ovf   = ovf;
        readdata     = '0;
        case (address)
            ADDR_PUSH:   readdata = 32'(head);
            ADDR_STATUS: readdata = status;
            ADDR_CTRL:   readdata[CTRL_IRQ_EN_BIT] = irq_en;
            ADDR_LAST:   readdata = 32'(last_word);
            default:     readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_soc_system_pio_stream_out.sv
// Bench for soc_system_pio_stream_out: directed table, corner sequences and
// random traffic against a queue-based reference model.
module tb_soc_system_pio_stream_out;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned LOW_WM = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        address;
    logic              chipselect;
    logic              write_n;
    logic [31:0]       writedata;
    logic [31:0]       readdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              irq;

    soc_system_pio_stream_out #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .LOW_WM (LOW_WM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model state
    logic [31:0] mq[$];
    logic        m_ovf    = 1'b0;
    logic        m_irq_en = 1'b0;
    logic        m_irq    = 1'b0;
    logic [31:0] m_last   = 32'd0;
    bit          model_ok = 1'b0;

    typedef struct {
        logic        rst;
        logic        cs;
        logic        wn;
        logic [1:0]  addr;
        logic [31:0] wd;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_data;
        logic        e_irq;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t tbl[19];

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endfunction

    function automatic logic [31:0] model_rdata(input logic [1:0] a);
        logic [31:0] r;
        r = 32'd0;
        case (a)
            2'd0: r = (mq.size() != 0) ? mq[0] : 32'd0;
            2'd1: begin
                r[15:0] = 16'(mq.size());
                r[16]   = (mq.size() == 0);
                r[17]   = (mq.size() == DEPTH);
                r[18]   = m_ovf;
            end
            2'd2: r[2] = m_irq_en;
            default: r = m_last;
        endcase
        return r;
    endfunction

    task automatic model_check();
        if (!model_ok) return;
        chk("model_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("model_data", 32'(out_data), (mq.size() != 0) ? mq[0] : 32'd0);
        chk("model_irq", 32'(irq), 32'(m_irq));
        chk("model_rdata", readdata, model_rdata(address));
    endtask

    // Advance the model by one clock using the inputs currently driven
    task automatic model_update();
        int unsigned sz;
        bit wr, do_pop, irq_nx;
        if (reset) begin
            mq.delete();
            m_ovf = 1'b0; m_irq_en = 1'b0; m_last = 32'd0; m_irq = 1'b0;
            model_ok = 1'b1;
            return;
        end
        if (!model_ok) return;
        sz     = 32'(mq.size());
        irq_nx = m_irq_en && (sz <= LOW_WM);
        wr     = chipselect && !write_n;
        do_pop = (sz > 0) && out_ready;
        if (wr && address == 2'd2 && writedata[0]) mq.delete();
        else if (do_pop) void'(mq.pop_front());
        if (wr && address == 2'd0) begin
            if (sz < DEPTH || do_pop) begin
                mq.push_back(writedata);
                m_last = writedata;
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (wr && address == 2'd2) begin
            m_irq_en = writedata[2];
            if (writedata[1]) m_ovf = 1'b0;
        end
        m_irq = irq_nx;
    endtask

    task automatic drive(input logic rst, input logic cs, input logic wn, input logic [1:0] a,
                         input logic [31:0] wd, input logic rdy);
        reset = rst; chipselect = cs; write_n = wn; address = a; writedata = wd; out_ready = rdy;
        #1;
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] w, input logic rdy);
        drive(1'b0, 1'b1, 1'b0, 2'd0, w, rdy);
        tick();
    endtask

    task automatic ctrl(input logic [31:0] v, input logic rdy);
        drive(1'b0, 1'b1, 1'b0, 2'd2, v, rdy);
        tick();
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string name, input logic rdy);
        drive(1'b0, 1'b1, 1'b1, a, 32'd0, rdy);
        chk(name, readdata, exp);
        tick();
    endtask

    logic [31:0] drain_exp[8];
    logic [1:0]  r_addr;
    logic [31:0] r_wd;
    logic        r_rdy;
    int unsigned thr;

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 2'd1, 32'h0,  1'b0, 1'b0, 32'h0,  1'b0, 32'h10000};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h11, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h22, 1'b0, 1'b1, 32'h11, 1'b0, 32'h11};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h33, 1'b0, 1'b1, 32'h11, 1'b0, 32'h11};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 2'd1, 32'h0,  1'b0, 1'b1, 32'h11, 1'b0, 32'h3};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 2'd0, 32'h0,  1'b0, 1'b1, 32'h11, 1'b0, 32'h11};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 2'd3, 32'h0,  1'b0, 1'b1, 32'h11, 1'b0, 32'h33};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 2'd2, 32'h4,  1'b0, 1'b1, 32'h11, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 2'd2, 32'h0,  1'b0, 1'b1, 32'h11, 1'b0, 32'h4};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 2'd2, 32'h0,  1'b0, 1'b1, 32'h11, 1'b0, 32'h4};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 2'd1, 32'h0,  1'b1, 1'b1, 32'h11, 1'b0, 32'h3};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 2'd1, 32'h0,  1'b0, 1'b1, 32'h22, 1'b0, 32'h2};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 2'd1, 32'h0,  1'b0, 1'b1, 32'h22, 1'b1, 32'h2};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 2'd2, 32'h5,  1'b1, 1'b1, 32'h22, 1'b1, 32'h4};
        tbl[14] = '{1'b0, 1'b1, 1'b1, 2'd1, 32'h0,  1'b1, 1'b0, 32'h0,  1'b1, 32'h10000};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 2'd1, 32'h0,  1'b0, 1'b0, 32'h0,  1'b1, 32'h10000};
        tbl[16] = '{1'b1, 1'b1, 1'b1, 2'd2, 32'h0,  1'b0, 1'b0, 32'h0,  1'b1, 32'h4};
        tbl[17] = '{1'b0, 1'b1, 1'b1, 2'd2, 32'h0,  1'b0, 1'b0, 32'h0,  1'b0, 32'h0};
        tbl[18] = '{1'b0, 1'b1, 1'b1, 2'd3, 32'h0,  1'b0, 1'b0, 32'h0,  1'b0, 32'h0};

        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
        writedata = 32'd0; out_ready = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 2'd0, 32'd0, 1'b0);
        tick();
        tick();

        // Directed table: push/head/status, irq watermark, flush, reset
        for (int i = 0; i < 19; i++) begin
            drive(tbl[i].rst, tbl[i].cs, tbl[i].wn, tbl[i].addr, tbl[i].wd, tbl[i].rdy);
            chk($sformatf("t%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_valid));
            chk($sformatf("t%0d_data", i), 32'(out_data), tbl[i].e_data);
            chk($sformatf("t%0d_irq", i), 32'(irq), 32'(tbl[i].e_irq));
            chk($sformatf("t%0d_rdata", i), readdata, tbl[i].e_rdata);
            tick();
        end

        // Overflow at full, sticky OVF, LAST ignores dropped word
        drive(1'b1, 1'b0, 1'b1, 2'd0, 32'd0, 1'b0);
        tick();
        for (int i = 1; i <= 8; i++) push(32'h100 + 32'(i), 1'b0);
        rd(2'd1, 32'h20008, "status_full", 1'b0);
        push(32'h109, 1'b0);
        rd(2'd1, 32'h60008, "status_ovf", 1'b0);
        rd(2'd3, 32'h108, "last_8th", 1'b0);
        ctrl(32'h2, 1'b0);
        rd(2'd1, 32'h20008, "ovf_cleared", 1'b0);

        // Push while full and popping is accepted and delivered last
        push(32'hAA, 1'b1);
        rd(2'd1, 32'h20008, "full_push_pop", 1'b0);
        for (int k = 0; k < 8; k++) drain_exp[k] = (k < 7) ? 32'h102 + 32'(k) : 32'hAA;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b0, 1'b1, 2'd0, 32'd0, 1'b1);
            chk($sformatf("drain%0d", k), 32'(out_data), drain_exp[k]);
            tick();
        end
        rd(2'd1, 32'h10000, "drained", 1'b0);

        // Flush beats a same-cycle pop
        for (int i = 0; i < 5; i++) push(32'h200 + 32'(i), 1'b0);
        ctrl(32'h1, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 2'd1, 32'd0, 1'b0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_status", readdata, 32'h10000);
        tick();
        push(32'h300, 1'b0);
        rd(2'd0, 32'h300, "post_flush_head", 1'b0);

        // Reset mid-stream with OVF and IRQ_EN set
        ctrl(32'h4, 1'b0);
        for (int i = 0; i < 8; i++) push(32'h400 + 32'(i), 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, 2'd0, 32'd0, 1'b1);
            tick();
        end
        rd(2'd1, 32'h40003, "pre_reset_status", 1'b0);
        drive(1'b1, 1'b0, 1'b1, 2'd0, 32'd0, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 2'd1, 32'd0, 1'b0);
        chk("rst_status", readdata, 32'h10000);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        tick();
        rd(2'd2, 32'd0, "rst_ctrl", 1'b0);
        rd(2'd3, 32'd0, "rst_last", 1'b0);

        // Random traffic against the model
        thr = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) thr = $urandom_range(5, 95);
            r_addr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            r_wd   = $urandom;
            if (r_addr == 2'd2) r_wd[0] = ($urandom_range(0, 15) == 0);
            r_rdy  = ($urandom_range(0, 99) < thr);
            drive(($urandom_range(0, 399) == 0), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) == 0), r_addr, r_wd, r_rdy);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
